branch_bht: RTL and testbench
=============================

# branch_bht

Branch history table and resolution unit for the RV32I core. Holds one 2-bit saturating predictor per indexed PC and answers combinational taken/not-taken lookups from fetch. It sits directly downstream of the execute-stage comparator and consumes its `br_en` to train the table. It detects mispredictions and issues a registered flush and redirect PC back to fetch.

## Interface
- `ENTRIES`, 64: number of predictor entries; power of two, 4..1024.
- `IDX_W`, `$clog2(ENTRIES)`: index width; derived, not overridden.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pred_pc`  in  32  fetch PC to look up.
- `pred_taken`  out  1  combinational prediction for `pred_pc`.
- `ex_valid`  in  1  execute-stage instruction is valid this cycle.
- `ex_is_br`  in  1  execute instruction is a conditional branch.
- `ex_pc`  in  32  PC of the execute instruction.
- `ex_br_en`  in  1  resolved branch outcome from the comparator.
- `ex_pred_taken`  in  1  prediction made at fetch, carried down the pipe.
- `ex_target`  in  32  computed branch target (`ex_pc` + B-imm).
- `flush`  out  1  registered; squash younger instructions and redirect.
- `redirect_pc`  out  32  registered; correct next PC, valid when `flush`=1.
- `br_count`  out  32  resolved branches since reset.
- `mispred_count`  out  32  mispredicted branches since reset.

## Operation
- Index = `pc[IDX_W+1:2]` for both lookup and update. No tags; aliasing is accepted.
- Counter encoding: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Prediction is bit[1] of the counter.
- Lookup: `pred_taken = table[idx(pred_pc)][1]`, purely combinational.
- Resolve event: `res = ex_valid & ex_is_br & ~flush`.
  - While `flush`=1, the execute-stage instruction is wrong-path. It is ignored: no training, no counts, no new flush.
- Training on `res`:
  - If `ex_br_en`=1, the entry increments, saturating at ST.
  - If `ex_br_en`=0, the entry decrements, saturating at SNT.
- Mispredict: `mis = res & (ex_br_en != ex_pred_taken)`.
- Redirect target:
  - If `ex_br_en`=1, `redirect_pc` = `ex_target`.
  - Otherwise, `redirect_pc` = `ex_pc + 32'd4` (mod 2^32).
- Counters:
  - `br_count` increments on `res`.
  - `mispred_count` increments on `mis`.
  - Both wrap at 2^32.
- Non-branch valid instructions (`ex_is_br`=0) have no effect.

## Timing
- Reset values:
  - All table entries = WNT.
  - `flush`=0, `redirect_pc`=32'h0, `br_count`=0, `mispred_count`=0.
  - `pred_taken` therefore reads 0 after reset.
- Flush latency:
  - `flush` rises on the edge after the cycle `mis` is true.
  - It is high for exactly one cycle, then returns to 0 unless a new `mis` occurs.
  - A new `mis` cannot occur in that cycle because of squash.
- `redirect_pc` is loaded only on `mis` and holds its value otherwise.
- Table write takes effect at the edge ending the resolve cycle.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value. There is no bypass.
- `rst` mid-operation:
  - A pending `flush` is cleared.
  - The table returns to WNT and all counts clear on that edge.
  - `rst` overrides every other input.

## Structure
- `rv32i_types` gets:
  - enum `bht_state_t` {SNT, WNT, WT, ST}
  - constant `BHT_RESET_STATE = WNT`
- Sub-module `bht_sat_counter`: 2-bit saturating up/down counter with synchronous reset to WNT. It is instantiated `ENTRIES` times with a per-entry write enable.
- The top level holds the index decode, the mispredict compare, the flush/redirect registers and the statistics counters.

## Test plan
- **Reset then lookup.** Assert `rst` 1 cycle, then `pred_pc`=0x100 → `pred_taken`=0, `flush`=0, both counts 0.
- **Training.** Three taken resolves at `ex_pc`=0x100 (`ex_pred_taken`=0 first, then 1) → entry goes WNT→WT→ST→ST.
  - Only the first resolve causes `flush`; `mispred_count`=1, `br_count`=3.
- **Not-taken mispredict.** Entry at ST, `ex_pred_taken`=1, `ex_br_en`=0, `ex_pc`=0x2000 → next cycle `flush`=1, `redirect_pc`=0x2004; entry becomes WT.
- **Squash.** A mispredict with `ex_target`=0x3000 is followed the next cycle by a valid branch whose `ex_br_en` differs from its `ex_pred_taken`.
  - Only one `flush` is issued, with `redirect_pc`=0x3000.
  - The second branch does not train its entry or increment counts.
- **Aliasing and same-cycle read/write.** `pred_pc`=0x100 and `ex_pc`=0x100+4·ENTRIES updated in the same cycle → `pred_taken` shows the old value; next cycle it shows the new value.
- **Reset mid-operation.** Assert `rst` the same cycle as `mis` → next cycle `flush`=0, `redirect_pc`=0, table all WNT.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types; this slice carries the branch-predictor state encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    localparam bht_state_t BHT_RESET_STATE = WNT;

endpackage

// File: rtl/bht_sat_counter.sv
// One 2-bit saturating up/down predictor entry; moves one step toward the
// resolved outcome whenever its write enable is asserted.
module bht_sat_counter
    import rv32i_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic       taken_i,
    output bht_state_t state_o
);

    bht_state_t state_q, state_d;

    // NOTE: state_d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (we_i) begin
            if (taken_i) begin
                if (state_q != ST) state_d = bht_state_t'(state_q + 2'd1);
            end else begin
                if (state_q != SNT) state_d = bht_state_t'(state_q - 2'd1);
            end
        end
    end

    // NOTE: every entry is reset because a cold predictor must start at WNT;
    // state registers use <= so all entries update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= BHT_RESET_STATE;
        else     state_q <= state_d;
    end

    assign state_o = state_q;

endmodule

// File: rtl/branch_bht.sv
// Branch history table with resolve-stage training, mispredict detection,
// registered flush/redirect back to fetch and branch statistics.
module branch_bht
    import rv32i_types::*;
#(
    parameter int ENTRIES = 64,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pred_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic [31:0] ex_pc,
    input  logic        ex_br_en,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    logic [IDX_W-1:0] pred_idx, ex_idx;
    logic             res, mis;
    bht_state_t       entry_state [ENTRIES];

    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign ex_idx   = ex_pc[IDX_W+1:2];

    // Address bits outside the index are deliberately ignored (untagged table).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], ex_pc[1:0]};

    // The instruction in execute while a flush is out is wrong-path.
    assign res = ex_valid & ex_is_br & ~flush_q;
    assign mis = res & (ex_br_en != ex_pred_taken);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        bht_sat_counter u_ctr (
            .clk     (clk),
            .rst     (rst),
            .we_i    (res && (ex_idx == IDX_W'(i))),
            .taken_i (ex_br_en),
            .state_o (entry_state[i])
        );
    end

    assign pred_taken = entry_state[pred_idx][1];

    always_comb begin
        flush_d    = mis;
        redirect_d = redirect_q;
        br_cnt_d   = br_cnt_q + {31'd0, res};
        mis_cnt_d  = mis_cnt_q + {31'd0, mis};
        if (mis) redirect_d = ex_br_en ? ex_target : ex_pc + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q    <= 1'b0;
            redirect_q <= 32'h0;
            br_cnt_q   <= 32'd0;
            mis_cnt_q  <= 32'd0;
        end else begin
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_bht.sv
// Directed bench for branch_bht: training, mispredict flush, squash, aliasing, reset.
module tb_branch_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        ex_valid, ex_is_br, ex_br_en, ex_pred_taken;
    logic [31:0] ex_pc, ex_target;
    logic        flush;
    logic [31:0] redirect_pc, br_count, mispred_count;

    int n_checks = 0;
    int n_pass   = 0;

    branch_bht #(.ENTRIES(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_br      (ex_is_br),
        .ex_pc         (ex_pc),
        .ex_br_en      (ex_br_en),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [31:0] pc, input logic br_en, input logic pt,
                          input logic [31:0] tgt);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = pc;
        ex_br_en = br_en; ex_pred_taken = pt; ex_target = tgt;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_is_br = 1'b0;
    endtask

    task automatic stats(input string tag, input logic f, input logic [31:0] rpc,
                         input logic [31:0] nb, input logic [31:0] nm);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
        check({tag, ".redirect"}, redirect_pc, rpc);
        check({tag, ".br_count"}, br_count, nb);
        check({tag, ".mispred"}, mispred_count, nm);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        check(tag, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst = 1'b1; pred_pc = 32'h100; ex_pc = 32'h0; ex_target = 32'h0;
        ex_br_en = 1'b0; ex_pred_taken = 1'b0;
        idle();
        #2;
        step();
        rst = 1'b0;

        // Reset then lookup
        lookup("reset.pred", 32'h100, 1'b0);
        stats("reset", 1'b0, 32'h0, 0, 0);

        // Training at 0x100 (idx 0): WNT->WT mispredict, then WT->ST, ST->ST
        branch(32'h100, 1'b1, 1'b0, 32'h180);
        step();
        stats("train1", 1'b1, 32'h180, 1, 1);
        lookup("train1.pred", 32'h100, 1'b1);
        idle();
        step();
        check("train1.flush_drop", {31'd0, flush}, 32'd0);
        branch(32'h100, 1'b1, 1'b1, 32'h180);
        step();
        stats("train2", 1'b0, 32'h180, 2, 1);
        step();
        stats("train3", 1'b0, 32'h180, 3, 1);
        lookup("train3.pred", 32'h100, 1'b1);

        // Not-taken mispredict at 0x2000 (aliases idx 0): ST->WT
        branch(32'h2000, 1'b0, 1'b1, 32'h2800);
        step();
        stats("nt_mis", 1'b1, 32'h2004, 4, 2);
        lookup("nt_mis.pred", 32'h100, 1'b1);
        idle();
        step();

        // Squash: second branch during flush is ignored
        branch(32'h104, 1'b1, 1'b0, 32'h3000);
        step();
        stats("squash1", 1'b1, 32'h3000, 5, 3);
        branch(32'h104, 1'b0, 1'b1, 32'h5000);
        step();
        stats("squash2", 1'b0, 32'h3000, 5, 3);
        lookup("squash.pred", 32'h104, 1'b1);
        idle();
        step();

        // Aliasing + same-cycle read/write: 0x200 shares idx 0 with 0x100 (WT->WNT)
        branch(32'h200, 1'b0, 1'b1, 32'h900);
        lookup("alias.old", 32'h100, 1'b1);
        step();
        check("alias.new", {31'd0, pred_taken}, 32'd0);
        stats("alias", 1'b1, 32'h204, 6, 4);
        idle();
        step();

        // Non-branch valid instruction has no effect
        ex_valid = 1'b1; ex_is_br = 1'b0; ex_pc = 32'h104; ex_br_en = 1'b0; ex_pred_taken = 1'b1;
        step();
        stats("nonbr", 1'b0, 32'h204, 6, 4);
        lookup("nonbr.pred", 32'h104, 1'b1);

        // Reset on the same cycle as a mispredict
        branch(32'h108, 1'b1, 1'b0, 32'h4000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        stats("midrst", 1'b0, 32'h0, 0, 0);
        lookup("midrst.pred0", 32'h100, 1'b0);
        lookup("midrst.pred1", 32'h104, 1'b0);
        step();
        check("midrst.noflush", {31'd0, flush}, 32'd0);

        // Saturation at SNT: two not-taken from WNT, then one taken -> WNT (predicts 0)
        branch(32'h10C, 1'b0, 1'b0, 32'h0);
        step();
        step();
        stats("sat_snt", 1'b0, 32'h0, 2, 0);
        branch(32'h10C, 1'b1, 1'b0, 32'h6000);
        step();
        idle();
        stats("sat_up", 1'b1, 32'h6000, 3, 1);
        lookup("sat.pred", 32'h10C, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
